// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: phase codes, the decode
// result type and the pure transition-classification function.
package quad_pkg;

  // Phase codes are {A, B}. The up sequence is 00 -> 01 -> 11 -> 10 -> 00.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_UP   = 2'd1,
    DEC_DOWN = 2'd2,
    DEC_ERR  = 2'd3
  } dec_e;

  // Phase that follows 'ph' when the encoder turns in the up direction.
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] res;
    case (ph)
      PH_00:   res = PH_01;
      PH_01:   res = PH_11;
      PH_11:   res = PH_10;
      default: res = PH_00;
    endcase
    return res;
  endfunction

  // Classify a phase transition. Both bits changing at once is illegal for
  // a Gray-coded source, so it is reported instead of guessed at.
  function automatic dec_e decode(input logic [1:0] prev, input logic [1:0] next);
    dec_e res;
    if (prev == next) begin
      res = DEC_NONE;
    end else if ((prev ^ next) == 2'b11) begin
      res = DEC_ERR;
    end else if (next == next_up(prev)) begin
      res = DEC_UP;
    end else begin
      res = DEC_DOWN;
    end
    return res;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder channel: a flop-chain synchroniser followed by a glitch filter
// that only accepts a new level after it has been stable for FILTER_LEN cycles.
// The next filtered value is exported so the decoder can act on the same edge
// the filter updates.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_filt,
  output logic o_filt_next
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_filt;
  logic                   w_filt_next;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_next;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end
  end

  // Count consecutive disagreement cycles; accept the new level on the last one.
  always_comb begin
    w_filt_next = r_filt;
    w_cnt_next  = r_cnt;
    if (w_sync == r_filt) begin
      w_cnt_next = {CW{1'b0}};
    end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
      w_filt_next = w_sync;
      w_cnt_next  = {CW{1'b0}};
    end else begin
      w_cnt_next = r_cnt + CW'(1);
    end
  end

  // Register the filtered level and its stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt <= 1'b0;
      r_cnt  <= {CW{1'b0}};
    end else begin
      r_filt <= w_filt_next;
      r_cnt  <= w_cnt_next;
    end
  end

  assign o_filt      = r_filt;
  assign o_filt_next = w_filt_next;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: filtered channels feed a transition decoder that
// drives a wrap-around position count, direction, step pulse and a sticky
// illegal-transition flag. A warm-up period after reset lets the filters
// settle onto the pin levels without producing events.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clr_cnt,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int WARM_CYC = SYNC_STAGES + FILTER_LEN + 1;
  localparam int WW       = $clog2(WARM_CYC + 1);

  logic             w_a_f;
  logic             w_a_f_next;
  logic             w_b_f;
  logic             w_b_f_next;
  logic [1:0]       w_ph_cur;
  logic [1:0]       w_ph_nxt;
  dec_e             w_dec;
  logic             w_dec_en;
  logic             w_illegal;

  logic [WW-1:0]    r_warm;
  logic [WW-1:0]    w_warm_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_dir;
  logic             w_dir_next;
  logic             r_step;
  logic             w_step_next;
  logic             r_err;
  logic             w_err_next;

  quad_input_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filt_a (
    .clk         (clk),
    .reset       (reset),
    .i_pin       (quad_a),
    .o_filt      (w_a_f),
    .o_filt_next (w_a_f_next)
  );

  quad_input_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filt_b (
    .clk         (clk),
    .reset       (reset),
    .i_pin       (quad_b),
    .o_filt      (w_b_f),
    .o_filt_next (w_b_f_next)
  );

  assign w_ph_cur  = {w_a_f, w_b_f};
  assign w_ph_nxt  = {w_a_f_next, w_b_f_next};
  assign w_dec     = decode(w_ph_cur, w_ph_nxt);
  assign w_dec_en  = (r_warm == WW'(WARM_CYC));
  assign w_illegal = w_dec_en && (w_dec == DEC_ERR);

  // Next-state for warm-up, count, direction, step and error.
  always_comb begin
    w_warm_next  = r_warm;
    w_count_next = r_count;
    w_dir_next   = r_dir;
    w_step_next  = 1'b0;
    w_err_next   = r_err;

    if (w_dec_en) begin
      w_warm_next = r_warm;
    end else begin
      w_warm_next = r_warm + WW'(1);
    end

    if (w_dec_en) begin
      case (w_dec)
        DEC_UP: begin
          w_count_next = r_count + CNT_W'(1);
          w_dir_next   = 1'b1;
          w_step_next  = 1'b1;
        end
        DEC_DOWN: begin
          w_count_next = r_count - CNT_W'(1);
          w_dir_next   = 1'b0;
          w_step_next  = 1'b1;
        end
        default: begin
          w_count_next = r_count;
        end
      endcase
    end else begin
      w_count_next = r_count;
    end

    // Clear wins over a coincident step; step and dir still report the event.
    if (clr_cnt) begin
      w_count_next = {CNT_W{1'b0}};
    end else begin
      w_count_next = w_count_next;
    end

    // A fresh illegal transition beats a simultaneous clear request.
    if (w_illegal) begin
      w_err_next = 1'b1;
    end else if (err_clr) begin
      w_err_next = 1'b0;
    end else begin
      w_err_next = r_err;
    end
  end

  // Register all outputs and the warm-up counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_warm  <= {WW{1'b0}};
      r_count <= {CNT_W{1'b0}};
      r_dir   <= 1'b1;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_warm  <= w_warm_next;
      r_count <= w_count_next;
      r_dir   <= w_dir_next;
      r_step  <= w_step_next;
      r_err   <= w_err_next;
    end
  end

  assign count = r_count;
  assign dir   = r_dir;
  assign step  = r_step;
  assign err   = r_err;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder. Each phase change that should yield
// a step pushes the expected count, direction and arrival cycle; a monitor
// pops and compares whenever step is seen.
module tb_quadrature_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        quad_a;
  logic        quad_b;
  logic        clr_cnt;
  logic        err_clr;
  logic [15:0] count;
  logic        dir;
  logic        step;
  logic        err;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] cnt;
    logic        d;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_step = 1'b0;

  // Model state.
  logic [1:0]  m_ph;
  logic [15:0] m_cnt;
  logic        m_dir;
  logic        m_err;

  // Successor / predecessor of each {A,B} phase in the up direction.
  logic [1:0] up_tab [0:3] = '{2'b01, 2'b11, 2'b00, 2'b10};
  logic [1:0] dn_tab [0:3] = '{2'b10, 2'b00, 2'b11, 2'b01};

  quadrature_decoder #(
    .CNT_W       (16),
    .SYNC_STAGES (2),
    .FILTER_LEN  (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .quad_a  (quad_a),
    .quad_b  (quad_b),
    .clr_cnt (clr_cnt),
    .err_clr (err_clr),
    .count   (count),
    .dir     (dir),
    .step    (step),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every step must be expected, on time, with the right state.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      check("step_not_back_to_back", {31'd0, prev_step}, 32'd0);
      check("step_expected", {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("step_count", {16'd0, count}, {16'd0, mon_e.cnt});
        check("step_dir", {31'd0, dir}, {31'd0, mon_e.d});
        check("step_cycle", cyc, mon_e.at);
      end
    end
    prev_step <= step;
  end

  // Drive a new phase at a falling edge, updating the model and scoreboard.
  task automatic drive(input logic [1:0] ph, input bit with_clr);
    @(negedge clk);
    if (ph != m_ph) begin
      if ((ph ^ m_ph) == 2'b11) begin
        m_err = 1'b1;
      end else begin
        if (ph == up_tab[m_ph]) begin
          m_cnt = m_cnt + 16'd1;
          m_dir = 1'b1;
        end else begin
          m_cnt = m_cnt - 16'd1;
          m_dir = 1'b0;
        end
        if (with_clr) m_cnt = 16'd0;
        sb.push_back('{m_cnt, m_dir, cyc + 5});
      end
    end
    {quad_a, quad_b} = ph;
    m_ph = ph;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    reset = 1'b1; quad_a = 1'b1; quad_b = 1'b1; clr_cnt = 1'b0; err_clr = 1'b0;
    m_ph = 2'b11; m_cnt = 16'd0; m_dir = 1'b1; m_err = 1'b0;
    idle(3);
    check("rst_count", {16'd0, count}, 32'd0);
    check("rst_dir", {31'd0, dir}, 32'd1);
    check("rst_step", {31'd0, step}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    idle(10);
    check("warm11_count", {16'd0, count}, 32'd0);
    check("warm11_err", {31'd0, err}, 32'd0);
    check("warm11_dir", {31'd0, dir}, 32'd1);

    // Restart from A=B=0.
    reset = 1'b1; quad_a = 1'b0; quad_b = 1'b0; m_ph = 2'b00;
    idle(3);
    reset = 1'b0;
    idle(10);

    // Eight up phases, then three down.
    for (int i = 0; i < 8; i++) begin drive(up_tab[m_ph], 1'b0); idle(10); end
    check("up8_count", {16'd0, count}, {16'd0, m_cnt});
    check("up8_dir", {31'd0, dir}, 32'd1);
    for (int i = 0; i < 3; i++) begin drive(dn_tab[m_ph], 1'b0); idle(10); end
    check("dn3_count", {16'd0, count}, 32'd5);
    check("dn3_dir", {31'd0, dir}, 32'd0);

    // Down to zero, then wrap both ways.
    for (int i = 0; i < 5; i++) begin drive(dn_tab[m_ph], 1'b0); idle(10); end
    check("zero_count", {16'd0, count}, 32'd0);
    drive(dn_tab[m_ph], 1'b0); idle(10);
    check("wrap_dn_count", {16'd0, count}, 32'h0000FFFF);
    drive(up_tab[m_ph], 1'b0); idle(10);
    check("wrap_up_count", {16'd0, count}, 32'd0);
    check("wrap_err", {31'd0, err}, 32'd0);

    // Two-cycle glitch on A is rejected; three cycles is accepted.
    @(negedge clk); quad_a = 1'b1;
    idle(2); quad_a = 1'b0;
    idle(10);
    check("glitch_count", {16'd0, count}, 32'd0);
    drive(2'b10, 1'b0); idle(2);
    drive(2'b00, 1'b0); idle(10);
    check("accept3_count", {16'd0, count}, 32'd0);

    // Illegal 00->11 transition, sticky until cleared.
    drive(2'b11, 1'b0); idle(10);
    check("illegal_err", {31'd0, err}, 32'd1);
    check("illegal_count", {16'd0, count}, 32'd0);
    drive(up_tab[m_ph], 1'b0); idle(10);
    drive(up_tab[m_ph], 1'b0); idle(10);
    check("sticky_err", {31'd0, err}, 32'd1);
    check("sticky_count", {16'd0, count}, 32'd2);
    err_clr = 1'b1; idle(1); err_clr = 1'b0; idle(1);
    check("errclr_err", {31'd0, err}, 32'd0);
    drive(2'b11, 1'b0); idle(4);
    check("pre_coincide_err", {31'd0, err}, 32'd0);
    err_clr = 1'b1; idle(1); err_clr = 1'b0; idle(5);
    check("coincide_err", {31'd0, err}, 32'd1);

    // Count clear on the same edge as an up step at count 7.
    for (int i = 0; i < 5; i++) begin drive(up_tab[m_ph], 1'b0); idle(10); end
    check("pre_clr_count", {16'd0, count}, 32'd7);
    drive(up_tab[m_ph], 1'b1); idle(4);
    clr_cnt = 1'b1; idle(1); clr_cnt = 1'b0; idle(10);
    check("clr_count", {16'd0, count}, 32'd0);
    check("clr_dir", {31'd0, dir}, 32'd1);

    // Count to 42, then reset mid-sequence and confirm warm-up repeats.
    for (int i = 0; i < 42; i++) begin drive(up_tab[m_ph], 1'b0); idle(8); end
    check("cnt42", {16'd0, count}, 32'd42);
    reset = 1'b1; idle(1);
    check("midrst_count", {16'd0, count}, 32'd0);
    check("midrst_dir", {31'd0, dir}, 32'd1);
    check("midrst_err", {31'd0, err}, 32'd0);
    reset = 1'b0; m_cnt = 16'd0; m_dir = 1'b1; m_err = 1'b0;
    idle(12);
    check("rewarm_count", {16'd0, count}, 32'd0);
    check("rewarm_err", {31'd0, err}, 32'd0);
    drive(up_tab[m_ph], 1'b0); idle(10);
    check("post_warm_count", {16'd0, count}, {16'd0, m_cnt});
    check("post_warm_dir", {31'd0, dir}, 32'd1);
    check("post_warm_err", {31'd0, err}, {31'd0, m_err});

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
